// File: rtl/instruction_encoder.sv
// Encodes decoded RV64 instruction fields into 32-bit words and packs them two per 64-bit beat,
// low word first. Illegal types and out-of-range immediates are dropped and counted.
module instruction_encoder #(
    parameter int BUS_DATA_WIDTH  = 64,
    parameter int TYPE_WIDTH      = 3,
    parameter int REGISTER_WIDTH  = 5,
    parameter int IMMEDIATE_WIDTH = 32,
    parameter int ERR_COUNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [TYPE_WIDTH-1:0]      in_type,
    input  logic [6:0]                 in_opcode,
    input  logic [2:0]                 in_funct3,
    input  logic [6:0]                 in_funct7,
    input  logic [REGISTER_WIDTH-1:0]  in_rd,
    input  logic [REGISTER_WIDTH-1:0]  in_rs1,
    input  logic [REGISTER_WIDTH-1:0]  in_rs2,
    input  logic [IMMEDIATE_WIDTH-1:0] in_imm,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BUS_DATA_WIDTH-1:0]  out_data,
    output logic [1:0]                 out_mask,
    output logic                       err_pulse,
    output logic [ERR_COUNT_WIDTH-1:0] err_count,
    output logic                       dbg_state
);

    localparam logic [TYPE_WIDTH-1:0] T_R  = TYPE_WIDTH'(0);
    localparam logic [TYPE_WIDTH-1:0] T_I  = TYPE_WIDTH'(1);
    localparam logic [TYPE_WIDTH-1:0] T_S  = TYPE_WIDTH'(2);
    localparam logic [TYPE_WIDTH-1:0] T_SB = TYPE_WIDTH'(3);
    localparam logic [TYPE_WIDTH-1:0] T_U  = TYPE_WIDTH'(4);
    localparam logic [TYPE_WIDTH-1:0] T_UJ = TYPE_WIDTH'(5);

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;

    typedef enum logic {EMPTY = 1'b0, HALF = 1'b1} state_t;

    state_t                       state, state_n;
    logic [31:0]                  low_q, low_n;
    logic [31:0]                  word;
    logic                         legal;
    logic                         accept;
    logic                         load;
    logic                         drop;
    logic [BUS_DATA_WIDTH-1:0]    load_data;
    logic [1:0]                   load_mask;
    logic                         is_shift_fn;
    logic signed [IMMEDIATE_WIDTH-1:0] imm_s;

    // Handshake: a transfer happens on a rising edge where valid && ready. in_ready
    // only reflects whether the output slot can take a beat, never in_valid.
    assign in_ready  = !(out_valid && !out_ready);
    assign accept    = in_valid && in_ready;
    assign dbg_state = state;

    assign imm_s       = $signed(in_imm);
    assign is_shift_fn = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (in_type)
            T_R: begin
                word  = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
                legal = 1'b1;
            end
            T_I: begin
                if (in_opcode == OP_IMM && is_shift_fn) begin
                    word  = {in_funct7[6:1], in_imm[5:0], in_rs1, in_funct3, in_rd, in_opcode};
                    legal = (imm_s >= 0) && (imm_s <= 63);
                end else if (in_opcode == OP_IMM_32 && is_shift_fn) begin
                    word  = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
                    legal = (imm_s >= 0) && (imm_s <= 31);
                end else begin
                    word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                    legal = (imm_s >= -2048) && (imm_s <= 2047);
                end
            end
            T_S: begin
                word  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                legal = (imm_s >= -2048) && (imm_s <= 2047);
            end
            T_SB: begin
                word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                         in_imm[4:1], in_imm[11], in_opcode};
                legal = (imm_s >= -4096) && (imm_s <= 4094) && !in_imm[0];
            end
            T_U: begin
                word  = {in_imm[31:12], in_rd, in_opcode};
                legal = (in_imm[11:0] == 12'h000);
            end
            T_UJ: begin
                word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                legal = (imm_s >= -1048576) && (imm_s <= 1048574) && !in_imm[0];
            end
            default: begin
                word  = '0;
                legal = 1'b0;
            end
        endcase
    end

    // Every beat load coincides with an accept, and accept implies the slot is free.
    always_comb begin
        state_n   = state;
        low_n     = low_q;
        load      = 1'b0;
        load_data = '0;
        load_mask = 2'b00;
        drop      = 1'b0;
        if (accept) begin
            if (legal) begin
                if (state == EMPTY) begin
                    if (in_last) begin
                        load      = 1'b1;
                        load_data = {32'h0, word};
                        load_mask = 2'b01;
                    end else begin
                        low_n   = word;
                        state_n = HALF;
                    end
                end else begin
                    load      = 1'b1;
                    load_data = {word, low_q};
                    load_mask = 2'b11;
                    state_n   = EMPTY;
                end
            end else begin
                drop = 1'b1;
                if (state == HALF && in_last) begin
                    load      = 1'b1;
                    load_data = {32'h0, low_q};
                    load_mask = 2'b01;
                    state_n   = EMPTY;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= EMPTY;
            low_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_mask  <= 2'b00;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_n;
            low_q     <= low_n;
            err_pulse <= drop;
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= load_data;
                out_mask  <= load_mask;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (drop && (err_count != {ERR_COUNT_WIDTH{1'b1}})) begin
                err_count <= err_count + ERR_COUNT_WIDTH'(1);
            end
        end
    end

endmodule
